ldpc_ber_multi_regmap: RTL

// Multi-channel register map for the LDPC BER tester. It controls NUM_CHANNELS

---
 rtl/ldpc_ber_multi_regmap.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ldpc_ber_multi_regmap.sv
// uP register map for the multi-lane LDPC BER tester: per-lane control/counters,
// tear-free 64-bit reads and a shared, channel-tagged failed-block FIFO.

module ldpc_ber_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        wsel,
  input  logic [3:0]  wreg,
  input  logic [23:0] wdata,
  input  logic        rsel,
  input  logic [3:0]  rreg,
  input  logic [63:0] finished,
  input  logic [63:0] bit_errors,
  output logic        en,
  output logic        sw_resetn,
  output logic [15:0] factor,
  output logic [7:0]  offset,
  output logic [31:0] rdata
);
  logic        rst_pend;
  logic [31:0] fin_hi, err_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en        <= 1'b0;
      sw_resetn <= 1'b1;
      rst_pend  <= 1'b0;
      factor    <= '0;
      offset    <= '0;
      fin_hi    <= '0;
      err_hi    <= '0;
    end else begin
      // pend lines up with wack, so the low pulse lands the cycle after it
      rst_pend  <= wsel && (wreg == 4'h0) && wdata[1];
      sw_resetn <= ~rst_pend;
      if (wsel && wreg == 4'h0) en <= wdata[0];
      if (wsel && wreg == 4'h1) {offset, factor} <= wdata[23:0];
      if (rsel && rreg == 4'h2) fin_hi <= finished[63:32];
      if (rsel && rreg == 4'h4) err_hi <= bit_errors[63:32];
    end
  end

  always_comb begin
    rdata = '0;
    if (rsel) begin
      case (rreg)
        4'h0:    rdata = {31'h0, en};
        4'h1:    rdata = {8'h0, offset, factor};
        4'h2:    rdata = finished[31:0];
        4'h3:    rdata = fin_hi;
        4'h4:    rdata = bit_errors[31:0];
        4'h5:    rdata = err_hi;
        default: rdata = '0;
      endcase
    end
  end
endmodule

module ldpc_ber_multi_regmap #(
  parameter logic [31:0] ID            = 32'h0,
  parameter int          ADDRESS_WIDTH = 10,
  parameter int          NUM_CHANNELS  = 2,
  parameter int          FIFO_DEPTH    = 16
) (
  input  logic                        up_clk,
  input  logic                        up_reset,
  input  logic                        up_rreq,
  output logic                        up_rack,
  input  logic [ADDRESS_WIDTH-1:0]    up_raddr,
  output logic [31:0]                 up_rdata,
  input  logic                        up_wreq,
  output logic                        up_wack,
  input  logic [ADDRESS_WIDTH-1:0]    up_waddr,
  input  logic [31:0]                 up_wdata,
  output logic                        up_interrupt,
  output logic [NUM_CHANNELS-1:0]     ch_en,
  output logic [NUM_CHANNELS-1:0]     ch_sw_resetn,
  output logic [16*NUM_CHANNELS-1:0]  ch_factor,
  output logic [8*NUM_CHANNELS-1:0]   ch_offset,
  input  logic [64*NUM_CHANNELS-1:0]  ch_finished_blks,
  input  logic [64*NUM_CHANNELS-1:0]  ch_bit_errors,
  input  logic [NUM_CHANNELS-1:0]     ch_fail_valid,
  input  logic [64*NUM_CHANNELS-1:0]  ch_fail_id
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [31:0] scratch, drops, rd_word;
  logic [1:0]  irq_enable, irq_status;
  logic        ovf;
  logic        gsel_w, gsel_r, pop, full, nonempty;
  logic        push_any, push_ok, push_lost;
  logic [1:0]  push_ch;
  logic [63:0] push_id;
  logic [2:0]  n_fail, drop_inc;
  logic [32:0] drop_sum;
  logic [PW:0] wr_ptr, rd_ptr, level;
  logic [65:0] mem [FIFO_DEPTH];
  logic [65:0] head;
  logic [NUM_CHANNELS-1:0][31:0] lane_rdata;

  assign gsel_w = up_wreq && (up_waddr[AW-1:4] == '0);
  assign gsel_r = up_rreq && (up_raddr[AW-1:4] == '0);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
    localparam logic [AW-5:0] PAGE = (AW-4)'(4 + i);
    ldpc_ber_lane u_lane (
      .clk        (up_clk),
      .rst        (up_reset),
      .wsel       (up_wreq && (up_waddr[AW-1:4] == PAGE)),
      .wreg       (up_waddr[3:0]),
      .wdata      (up_wdata[23:0]),
      .rsel       (up_rreq && (up_raddr[AW-1:4] == PAGE)),
      .rreg       (up_raddr[3:0]),
      .finished   (ch_finished_blks[64*i +: 64]),
      .bit_errors (ch_bit_errors[64*i +: 64]),
      .en         (ch_en[i]),
      .sw_resetn  (ch_sw_resetn[i]),
      .factor     (ch_factor[16*i +: 16]),
      .offset     (ch_offset[8*i +: 8]),
      .rdata      (lane_rdata[i])
    );
  end

  assign level    = wr_ptr - rd_ptr;
  assign nonempty = (level != '0);
  assign full     = (level == (PW+1)'(FIFO_DEPTH));
  assign head     = nonempty ? mem[rd_ptr[PW-1:0]] : '0;
  assign pop      = gsel_w && (up_waddr[3:0] == 4'hE) && nonempty;

  always_comb begin
    push_any = 1'b0;
    push_ch  = '0;
    push_id  = '0;
    n_fail   = '0;
    for (int i = NUM_CHANNELS-1; i >= 0; i--) begin
      if (ch_fail_valid[i]) begin
        push_any = 1'b1;
        push_ch  = 2'(i);
        push_id  = ch_fail_id[64*i +: 64];
      end
    end
    for (int i = 0; i < NUM_CHANNELS; i++) n_fail = n_fail + 3'(ch_fail_valid[i]);
  end

  // a simultaneous pop frees the slot, so a push while full is still accepted
  assign push_ok   = push_any && (!full || pop);
  assign push_lost = push_any && !push_ok;
  assign drop_inc  = n_fail - 3'(push_any) + 3'(push_lost);
  assign drop_sum  = {1'b0, drops} + 33'(drop_inc);

  assign irq_status   = {ovf, nonempty};
  assign up_interrupt = |(irq_status & irq_enable);

  always_ff @(posedge up_clk) begin
    if (push_ok) mem[wr_ptr[PW-1:0]] <= {push_ch, push_id};
  end

  always_ff @(posedge up_clk or posedge up_reset) begin
    if (up_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drops      <= '0;
      ovf        <= 1'b0;
      scratch    <= '0;
      irq_enable <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      drops <= drop_sum[32] ? '1 : drop_sum[31:0];
      ovf   <= (ovf & ~(gsel_w && up_waddr[3:0] == 4'h9 && up_wdata[1])) | push_lost;
      if (gsel_w && up_waddr[3:0] == 4'h2) scratch    <= up_wdata;
      if (gsel_w && up_waddr[3:0] == 4'h8) irq_enable <= up_wdata[1:0];
    end
  end

  always_comb begin
    rd_word = '0;
    if (gsel_r) begin
      case (up_raddr[3:0])
        4'h0:    rd_word = 32'h00020061;
        4'h1:    rd_word = ID;
        4'h2:    rd_word = scratch;
        4'h3:    rd_word = 32'h4350444c;
        4'h4:    rd_word = 32'(NUM_CHANNELS);
        4'h8:    rd_word = {30'h0, irq_enable};
        4'h9:    rd_word = {30'h0, irq_status};
        4'hA:    rd_word = 32'(level);
        4'hB:    rd_word = head[31:0];
        4'hC:    rd_word = head[63:32];
        4'hD:    rd_word = {29'h0, head[65:64], nonempty};
        4'hF:    rd_word = drops;
        default: rd_word = '0;
      endcase
    end
    for (int i = 0; i < NUM_CHANNELS; i++) rd_word = rd_word | lane_rdata[i];
  end

  always_ff @(posedge up_clk or posedge up_reset) begin
    if (up_reset) begin
      up_rack  <= 1'b0;
      up_wack  <= 1'b0;
      up_rdata <= '0;
    end else begin
      up_rack  <= up_rreq;
      up_wack  <= up_wreq;
      up_rdata <= up_rreq ? rd_word : '0;
    end
  end
endmodule
